// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter
//   Shares a single WIDTH-bit adder (a + b + cin, with carry-out) between
//   NUM_REQ requesters. A round-robin arbiter picks one valid requester per
//   cycle, and the result is held in one output register tagged with the
//   winner's index.
//
//   Optional build macro: ADDER_RR_ARBITER_SUB_EN
//     When defined, a per-requester req_sub input is added. A requester with
//     req_sub=1 gets a - b (a + ~b + 1), its req_cin is ignored, and
//     rsp_cout=1 then means "no borrow".
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   [NUM_REQ]        request valid per requester
//   req_ready  out  [NUM_REQ]        one-hot (or zero) accept
//   req_a      in   [NUM_REQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   [NUM_REQ*WIDTH]  operand B, same packing
//   req_cin    in   [NUM_REQ]        carry-in per requester
//   req_sub    in   [NUM_REQ]        subtract select (only with the macro)
//   rsp_valid  out  result register holds a valid result
//   rsp_ready  in   consumer accepts the result
//   rsp_id     out  [ID_W]   winning requester index
//   rsp_sum    out  [WIDTH]  sum modulo 2^WIDTH
//   rsp_cout   out  carry-out of the add
//
// State | meaning
//   ST_EMPTY | no result held, rsp_valid=0
//   ST_FULL  | result register valid, rsp_valid=1

module adder_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
`ifdef ADDER_RR_ARBITER_SUB_EN
  input  logic [NUM_REQ-1:0]       req_sub,
`endif
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr, ptr_nxt;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic            grant_vld;
  logic            can_accept;
  logic [WIDTH-1:0] op_a, op_b;
  logic            op_cin;
  logic [WIDTH:0]  sum_full;

  // Round-robin search starting at ptr; the first hit wins.
  always_comb begin
    int idx;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  // Operand mux for the single shared adder.
  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_cin = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        op_a   = req_a[i*WIDTH +: WIDTH];
        op_b   = req_b[i*WIDTH +: WIDTH];
        op_cin = req_cin[i];
`ifdef ADDER_RR_ARBITER_SUB_EN
        if (req_sub[i]) begin
          op_b   = ~req_b[i*WIDTH +: WIDTH];
          op_cin = 1'b1;
        end
`endif
      end
    end
    sum_full = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};
  end

  // Next-state and handshake outputs. Reset gates all grants so nothing
  // transfers in a reset cycle.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    req_ready  = '0;
    can_accept = (state == ST_EMPTY) || rsp_ready;
    grant_vld  = can_accept && grant_found && !rst;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_vld && (grant_idx == ID_W'(i));
    end
    if (grant_vld) begin
      state_nxt = ST_FULL;
      ptr_nxt   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (state == ST_FULL && rsp_ready) begin
      state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Result payload only changes on a grant; a plain drain leaves it intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
    end else if (grant_vld) begin
      rsp_id   <= grant_idx;
      rsp_sum  <= sum_full[WIDTH-1:0];
      rsp_cout <= sum_full[WIDTH];
    end
  end

  assign rsp_valid = (state == ST_FULL);

endmodule

// File: tb/tb_adder_rr_arbiter.sv
module tb_adder_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_cin;
`ifdef ADDER_RR_ARBITER_SUB_EN
  logic [NUM_REQ-1:0]       req_sub;
`endif
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  adder_rr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
`ifdef ADDER_RR_ARBITER_SUB_EN
    .req_sub   (req_sub),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic cin);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_cin[i]              = cin;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [1:0] id,
                           input logic [15:0] sum, input logic cout);
    check({tag, "_valid"}, rsp_valid, v);
    check({tag, "_id"},    rsp_id,    id);
    check({tag, "_sum"},   rsp_sum,   sum);
    check({tag, "_cout"},  rsp_cout,  cout);
  endtask

  logic [15:0] rr_sum [4] = '{16'h1000, 16'h2001, 16'h3002, 16'h4003};

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b0;
`ifdef ADDER_RR_ARBITER_SUB_EN
    req_sub   = '0;
`endif

    // Reset: outputs cleared, no accept while rst is high.
    tick();
    check("rst_ready", req_ready, 4'b0000);
    check_rsp("rst", 1'b0, 2'd0, 16'h0000, 1'b0);
    tick();
    rst       = 1'b0;
    req_valid = 4'b0000;

    // Single request on port 0.
    set_op(0, 16'h1234, 16'h0001, 1'b0);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1 check("p0_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    check_rsp("p0", 1'b1, 2'd0, 16'h1235, 1'b0);

    // Increment wrap on port 2 (ptr=1, search 1,2), drain and grant together.
    set_op(2, 16'hFFFF, 16'h0000, 1'b1);
    req_valid = 4'b0100;
    #1 check("wrap_ready", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    check_rsp("wrap", 1'b1, 2'd2, 16'h0000, 1'b1);

    // Drain with no grant: valid drops, payload retained.
    tick();
    check_rsp("drain", 1'b0, 2'd2, 16'h0000, 1'b1);

    // Port 3 alone from ptr=3, leaves ptr=0.
    set_op(3, 16'h00FF, 16'h0001, 1'b1);
    req_valid = 4'b1000;
    #1 check("p3_ready", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0000;
    check_rsp("p3", 1'b1, 2'd3, 16'h0101, 1'b0);
    tick();
    check("p3_drain", rsp_valid, 1'b0);

    // All four valid continuously: grants 0,1,2,3,0 with no bubbles.
    set_op(0, 16'h1000, 16'h0000, 1'b0);
    set_op(1, 16'h2000, 16'h0001, 1'b0);
    set_op(2, 16'h3000, 16'h0002, 1'b0);
    set_op(3, 16'h4000, 16'h0003, 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % 4;
      #1 check("rr_ready", req_ready, 32'd1 << g);
      tick();
      check_rsp("rr", 1'b1, 2'(g), rr_sum[g], 1'b0);
    end
    req_valid = 4'b0000;
    tick();
    check("rr_drain", rsp_valid, 1'b0);

    // Backpressure: ptr=1, port 3 result held while port 1 waits.
    rsp_ready = 1'b0;
    set_op(3, 16'h0010, 16'h0020, 1'b0);
    req_valid = 4'b1000;
    #1 check("bp_first_ready", req_ready, 4'b1000);
    tick();
    set_op(1, 16'h0100, 16'h0200, 1'b1);
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_ready", req_ready, 4'b0000);
      check_rsp("bp_hold", 1'b1, 2'd3, 16'h0030, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_ready", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0000;
    check_rsp("bp_p1", 1'b1, 2'd1, 16'h0301, 1'b0);
    tick();
    check("bp_drain", rsp_valid, 1'b0);

    // Accept on port 2 (ptr=2 -> 3), then reset the following cycle.
    rsp_ready = 1'b0;
    set_op(2, 16'h0001, 16'h0001, 1'b0);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    check_rsp("pre_rst", 1'b1, 2'd2, 16'h0002, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_rsp("mid_rst", 1'b0, 2'd0, 16'h0000, 1'b0);
    // ptr back at 0: port 0 beats port 3.
    set_op(0, 16'h0002, 16'h0003, 1'b0);
    set_op(3, 16'h0100, 16'h0100, 1'b0);
    req_valid = 4'b1001;
    rsp_ready = 1'b1;
    #1 check("post_rst_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    check_rsp("post_rst", 1'b1, 2'd0, 16'h0005, 1'b0);
    tick();

`ifdef ADDER_RR_ARBITER_SUB_EN
    // Subtract: ptr=1, port 1 used; cin is ignored when sub=1.
    set_op(1, 16'h0005, 16'h0007, 1'b1);
    req_sub   = 4'b0010;
    req_valid = 4'b0010;
    tick();
    check_rsp("sub_borrow", 1'b1, 2'd1, 16'hFFFE, 1'b0);
    set_op(2, 16'h0007, 16'h0005, 1'b0);
    req_sub   = 4'b0100;
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    req_sub   = 4'b0000;
    check_rsp("sub_noborrow", 1'b1, 2'd2, 16'h0002, 1'b1);
    tick();
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
